// File: rtl/axi_mem_arb_if.sv
// One AXI link between a requester and the arbiter (or arbiter and shared slave).
// The request/response payloads are the same struct types the arbiter is built with.
interface axi_mem_arb_if #(
  parameter type req_t  = logic,
  parameter type resp_t = logic
);
  req_t  req;
  resp_t resp;

  modport master (output req, input  resp);
  modport slave  (input  req, output resp);
endinterface

// File: rtl/axi_mem_arb.sv
// Two-requester AXI arbiter onto one shared slave port; read and write are arbitrated independently.
// Define AXI_MEM_ARB_FIXED_PRIO_EN to make requester 0 always win ties (no round-robin pointers).
package axi_mem_arb_pkg;
  typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; } ax_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } w_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_t;
  typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_t;
  typedef struct packed {
    logic aw_valid; ax_t aw; logic w_valid; w_t w; logic b_ready;
    logic ar_valid; ax_t ar; logic r_ready;
  } req_t;
  typedef struct packed {
    logic aw_ready; logic w_ready; logic b_valid; b_t b;
    logic ar_ready; logic r_valid; r_t r;
  } resp_t;
endpackage

module axi_mem_arb #(
  parameter type req_t  = axi_mem_arb_pkg::req_t,
  parameter type resp_t = axi_mem_arb_pkg::resp_t
) (
  input  logic  clk_i,
  input  logic  arst_ni,
  input  req_t  m0_req_i,
  output resp_t m0_resp_o,
  input  req_t  m1_req_i,
  output resp_t m1_resp_o,
  output req_t  s_req_o,
  input  resp_t s_resp_i
);
  typedef enum logic [1:0] {WIDLE, WADDR, WDATA, WRESP} wstate_e;
  typedef enum logic [1:0] {RIDLE, RADDR, RDATA} rstate_e;

  wstate_e wstate_q;
  rstate_e rstate_q;
  logic    wgnt_q, rgnt_q;
  logic    wwin, rwin;
  logic    aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;
  req_t    mreq  [2];
  resp_t   mresp [2];

  assign mreq[0]   = m0_req_i;
  assign mreq[1]   = m1_req_i;
  assign m0_resp_o = mresp[0];
  assign m1_resp_o = mresp[1];

`ifdef AXI_MEM_ARB_FIXED_PRIO_EN
  assign wwin = !mreq[0].aw_valid;
  assign rwin = !mreq[0].ar_valid;
`else
  logic wprio_q, rprio_q;
  // Tie goes to the pointer; a sole requester wins outright.
  assign wwin = (mreq[0].aw_valid && mreq[1].aw_valid) ? wprio_q : mreq[1].aw_valid;
  assign rwin = (mreq[0].ar_valid && mreq[1].ar_valid) ? rprio_q : mreq[1].ar_valid;
`endif

  // Handshakes are seen on the slave side; routing already gated them by state.
  assign aw_hs     = s_req_o.aw_valid && s_resp_i.aw_ready;
  assign w_last_hs = s_req_o.w_valid && s_resp_i.w_ready && s_req_o.w.last;
  assign b_hs      = s_resp_i.b_valid && s_req_o.b_ready;
  assign ar_hs     = s_req_o.ar_valid && s_resp_i.ar_ready;
  assign r_last_hs = s_resp_i.r_valid && s_req_o.r_ready && s_resp_i.r.last;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wstate_q <= WIDLE;
      wgnt_q   <= 1'b0;
`ifndef AXI_MEM_ARB_FIXED_PRIO_EN
      wprio_q  <= 1'b0;
`endif
    end else begin
      unique case (wstate_q)
        WIDLE: if (mreq[0].aw_valid || mreq[1].aw_valid) begin
          wgnt_q   <= wwin;
          wstate_q <= WADDR;
        end
        WADDR: if (aw_hs) wstate_q <= WDATA;
        WDATA: if (w_last_hs) wstate_q <= WRESP;
        WRESP: if (b_hs) begin
          wstate_q <= WIDLE;
`ifndef AXI_MEM_ARB_FIXED_PRIO_EN
          wprio_q  <= !wgnt_q;
`endif
        end
        default: wstate_q <= WIDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rstate_q <= RIDLE;
      rgnt_q   <= 1'b0;
`ifndef AXI_MEM_ARB_FIXED_PRIO_EN
      rprio_q  <= 1'b0;
`endif
    end else begin
      unique case (rstate_q)
        RIDLE: if (mreq[0].ar_valid || mreq[1].ar_valid) begin
          rgnt_q   <= rwin;
          rstate_q <= RADDR;
        end
        RADDR: if (ar_hs) rstate_q <= RDATA;
        RDATA: if (r_last_hs) begin
          rstate_q <= RIDLE;
`ifndef AXI_MEM_ARB_FIXED_PRIO_EN
          rprio_q  <= !rgnt_q;
`endif
        end
        default: rstate_q <= RIDLE;
      endcase
    end
  end

  // Pure muxes on registered state/grant: no valid->ready path through arbitration.
  always_comb begin
    s_req_o  = '0;
    mresp[0] = '0;
    mresp[1] = '0;
    case (wstate_q)
      WADDR: begin
        s_req_o.aw_valid         = mreq[wgnt_q].aw_valid;
        s_req_o.aw               = mreq[wgnt_q].aw;
        mresp[wgnt_q].aw_ready   = s_resp_i.aw_ready;
      end
      WDATA: begin
        s_req_o.w_valid          = mreq[wgnt_q].w_valid;
        s_req_o.w                = mreq[wgnt_q].w;
        mresp[wgnt_q].w_ready    = s_resp_i.w_ready;
      end
      WRESP: begin
        mresp[wgnt_q].b_valid    = s_resp_i.b_valid;
        mresp[wgnt_q].b          = s_resp_i.b;
        s_req_o.b_ready          = mreq[wgnt_q].b_ready;
      end
      default: ;
    endcase
    case (rstate_q)
      RADDR: begin
        s_req_o.ar_valid         = mreq[rgnt_q].ar_valid;
        s_req_o.ar               = mreq[rgnt_q].ar;
        mresp[rgnt_q].ar_ready   = s_resp_i.ar_ready;
      end
      RDATA: begin
        mresp[rgnt_q].r_valid    = s_resp_i.r_valid;
        mresp[rgnt_q].r          = s_resp_i.r;
        s_req_o.r_ready          = mreq[rgnt_q].r_ready;
      end
      default: ;
    endcase
  end
endmodule
